// File: rtl/div_scheduler_if.sv
// ---------------------------------------------------------------------------
// div_scheduler_if
//
// Bundles every handshake and bus signal of div_scheduler:
//   request side   : req_valid, req_ready, req_x, req_y (NREQ lanes)
//   response side  : rsp_valid, rsp_ready, rsp_id, rsp_q, rsp_r, rsp_err
//   divider core   : div_start, div_x, div_y, div_q, div_r, div_done, div_error
//   status         : busy
//
// Modports:
//   slave  - the scheduler itself. It serves requests and produces responses.
//   master - the surroundings. They issue requests, take responses and host
//            the divider core.
//
// Lane i of req_x / req_y occupies [i*WIDTH +: WIDTH].
// ---------------------------------------------------------------------------
interface div_scheduler_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_x;
  logic [NREQ*WIDTH-1:0] req_y;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_q;
  logic [WIDTH-1:0]      rsp_r;
  logic                  rsp_err;

  logic                  div_start;
  logic [WIDTH-1:0]      div_x;
  logic [WIDTH-1:0]      div_y;
  logic [WIDTH-1:0]      div_q;
  logic [WIDTH-1:0]      div_r;
  logic                  div_done;
  logic                  div_error;

  logic                  busy;

  modport slave (
    input  req_valid, req_x, req_y, rsp_ready,
    input  div_q, div_r, div_done, div_error,
    output req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err,
    output div_start, div_x, div_y, busy
  );

  modport master (
    output req_valid, req_x, req_y, rsp_ready,
    output div_q, div_r, div_done, div_error,
    input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err,
    input  div_start, div_x, div_y, busy
  );
endinterface

// File: rtl/div_scheduler.sv
// ---------------------------------------------------------------------------
// div_scheduler
//
// Shares one iterative WIDTH-step divider core between NREQ requesters.
// - Arbitration is round-robin over the valid/ready request lanes.
// - The winning operands are registered and driven to the core.
// - The core runs through START -> RUN, and its result is returned on a
//   single valid/ready response port.
// - A zero divisor is answered directly and never reaches the core. The
//   answer is q = all ones, r = x, err = 1.
// - A watchdog bounds RUN. If the core never raises div_done, the response
//   is q = 0, r = 0, err = 1.
//
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - div_scheduler_if.slave, which carries:
//             request lanes, response port, divider-core port, busy
//
// Parameters:
//   NREQ  - requesters, 2..4
//   WIDTH - operand width, must match the core
//   IDW   - rsp_id width, 2**IDW >= NREQ
//
// Timing for a normal operation accepted in cycle T:
//   - div_start is high in T+1.
//   - The core iterates in T+2 .. T+WIDTH+1.
//   - div_done is seen in T+WIDTH+2.
//   - rsp_valid rises in T+WIDTH+3.
// A zero divisor gives rsp_valid in T+1.
// ---------------------------------------------------------------------------
module div_scheduler #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input logic           clock,
  input logic           reset,
  div_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } state_t;

  // The watchdog must be able to count up to WIDTH+4 RUN cycles.
  localparam int             WDW      = $clog2(WIDTH + 5);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(WIDTH + 4);
  localparam logic [WDW-1:0] WD_ONE   = WDW'(1);
  localparam logic [NREQ-1:0] LANE0   = NREQ'(1);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [WDW-1:0]   watchdog;
  logic [WDW-1:0]   wd_next;

  logic             div_start_q;
  logic [WIDTH-1:0] div_x_q;
  logic [WIDTH-1:0] div_y_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_q_q;
  logic [WIDTH-1:0] rsp_r_q;
  logic             rsp_err_q;
  logic             busy_q;

  logic             grant_any;
  logic [IDW-1:0]   grant_id;
  logic [WIDTH-1:0] sel_x;
  logic [WIDTH-1:0] sel_y;
  logic             accept;

  // Lane index base+off, wrapped modulo NREQ.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                              input int             off);
    return IDW'((int'(base) + off) % NREQ);
  endfunction

  // Round-robin search. The loop walks from the farthest candidate back to
  // rr_ptr itself. The last hit is therefore the closest valid lane
  // starting from rr_ptr, and no early exit is needed.
  always_comb begin
    // NOTE: every always_comb output gets a default first. A path that
    // leaves a signal unassigned would infer a latch.
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (|(bus.req_valid & (LANE0 << wrap_add(rr_ptr, k)))) begin
        grant_any = 1'b1;
        grant_id  = wrap_add(rr_ptr, k);
      end
    end
  end

  // Operand mux for the granted lane.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_id == IDW'(k)) begin
        sel_x = bus.req_x[k*WIDTH +: WIDTH];
        sel_y = bus.req_y[k*WIDTH +: WIDTH];
      end
    end
  end

  assign accept  = (state == IDLE) && grant_any;
  assign wd_next = watchdog + WD_ONE;

  // req_ready is combinational so that a grant costs no extra cycle.
  // It is gated by reset: while reset is held the state register already
  // reads IDLE, but no request may be accepted.
  assign bus.req_ready = (accept && !reset) ? (LANE0 << grant_id) : '0;

  // NOTE: the state register and all outputs use non-blocking assignments.
  // Every right-hand side then sees the pre-edge value, which is what the
  // hardware does.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the operand and result registers are reset along with the
      // control state. Their values are visible on the ports straight
      // after reset. This is a handful of flops, not a memory.
      state       <= IDLE;
      rr_ptr      <= '0;
      watchdog    <= '0;
      div_start_q <= 1'b0;
      div_x_q     <= '0;
      div_y_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_q_q     <= '0;
      rsp_r_q     <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      div_start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            div_x_q  <= sel_x;
            div_y_q  <= sel_y;
            rsp_id_q <= grant_id;
            rr_ptr   <= wrap_add(grant_id, 1);
            busy_q   <= 1'b1;
            if (sel_y == '0) begin
              // Answered locally; the core is never started.
              rsp_q_q     <= '1;
              rsp_r_q     <= sel_x;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state       <= RESP;
            end else begin
              div_start_q <= 1'b1;
              watchdog    <= '0;
              state       <= START;
            end
          end
        end

        // div_done is not looked at here. It can still be high from the
        // previous operation (or one aborted by reset), and the core only
        // reloads on the edge that ends this cycle.
        START: state <= RUN;

        RUN: begin
          watchdog <= wd_next;
          if (bus.div_done) begin
            rsp_q_q     <= bus.div_q;
            rsp_r_q     <= bus.div_r;
            rsp_err_q   <= bus.div_error;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else if (wd_next == WD_LIMIT) begin
            rsp_q_q     <= '0;
            rsp_r_q     <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.div_start = div_start_q;
  assign bus.div_x     = div_x_q;
  assign bus.div_y     = div_y_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_q     = rsp_q_q;
  assign bus.rsp_r     = rsp_r_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/div_scheduler.md
Name: div_scheduler

Overview:
- Shares one iterative 8-step divider core between NREQ requesters.
- Performs round-robin arbitration over valid/ready request ports, registers the operands, and sequences the core through start, run and completion.
- Returns quotient, remainder and requester ID on a single valid/ready response port.
- Intercepts divide-by-zero and guards against a hung core with a watchdog.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- WIDTH, 8, operand and result width; must match the divider core.
- IDW, 2, width of rsp_id; must satisfy 2^IDW >= NREQ.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- req_valid, input, NREQ, per-requester request valid.
- req_ready, output, NREQ, per-requester accept; one-hot or zero.
- req_x, input, NREQ*WIDTH, dividends; requester i occupies slice [i*WIDTH +: WIDTH].
- req_y, input, NREQ*WIDTH, divisors; same slicing as req_x.
- rsp_valid, output, 1, result available.
- rsp_ready, input, 1, consumer accepts the result.
- rsp_id, output, IDW, index of the requester that owns the result.
- rsp_q, output, WIDTH, quotient.
- rsp_r, output, WIDTH, remainder.
- rsp_err, output, 1, divide-by-zero, core error or watchdog timeout.
- div_start, output, 1, one-cycle pulse to the core's synchronous load input.
- div_x, output, WIDTH, registered dividend to the core.
- div_y, output, WIDTH, registered divisor to the core.
- div_q, input, WIDTH, quotient from the core.
- div_r, input, WIDTH, remainder from the core.
- div_done, input, 1, core done (count == 0).
- div_error, input, 1, core error flag.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset (asynchronous): state=IDLE; rr_ptr=0; req_ready=0; rsp_valid=0; rsp_id=0; rsp_q=0; rsp_r=0; rsp_err=0; div_start=0; div_x=0; div_y=0; watchdog=0; busy=0.
- States: IDLE, START, RUN, RESP.
- IDLE:
  - Grant g is the first requester with req_valid set, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[g]=1 combinationally; all other req_ready bits 0. req_ready is 0 in every other state.
  - On handshake (valid & ready): latch x, y and id=g into div_x, div_y and the ID register; set rr_ptr=(g+1) mod NREQ.
  - If y==0: go to RESP with rsp_q=all ones, rsp_r=x, rsp_err=1. The core is never started.
  - Otherwise: go to START.
- START:
  - div_start=1 for exactly this cycle; go to RUN.
  - div_done is ignored here, because it may still be high from the previous operation.
- RUN:
  - div_start=0; watchdog increments each cycle.
  - When div_done=1: capture div_q and div_r; set rsp_err=div_error; go to RESP.
  - When watchdog reaches WIDTH+4 without div_done: rsp_q=0, rsp_r=0, rsp_err=1; go to RESP.
  - Watchdog clears on entry to START.
- RESP:
  - rsp_valid=1; rsp_id, rsp_q, rsp_r and rsp_err are held stable until rsp_valid & rsp_ready.
  - After the handshake: rsp_valid=0 and state returns to IDLE on the next edge.
  - A new grant is possible in that IDLE cycle.
- div_x and div_y are held constant from accept until the next accept. The core samples them on every iteration.
- Latency for a normal operation accepted in cycle T (WIDTH=8):
  - div_start high in T+1.
  - Core iterates T+2..T+9.
  - div_done seen in T+10.
  - rsp_valid high in T+11, i.e. WIDTH+3 cycles after accept.
- Latency for a divide-by-zero accepted in cycle T: rsp_valid high in T+1.
- Throughput: one operation in flight at a time; no queuing.
- Simultaneous requests: exactly one is granted per IDLE cycle. Unserved requesters keep req_valid high and wait; requesters must not drop or change a request before it is accepted.
- rsp_ready high outside RESP has no effect.
- Reset mid-operation (any state):
  - The operation is dropped silently; outputs take their reset values.
  - The core is not restarted. Its stale done is ignored by the START rule.

Test Plan:
- req0 alone, x=200, y=7, rsp_ready=1 -> req_ready[0] high in the accept cycle; div_start pulses once; rsp_valid 11 cycles after accept with q=28, r=4, id=0, err=0.
- req0 (100/9) and req1 (255/16) both held valid from reset -> req0 served first (q=11, r=1, id=0), then req1 (q=15, r=15, id=1). Re-issue both: req0 granted again (rr_ptr=0 after serving 1). Repeat 4 rounds to confirm strict alternation.
- req1 x=5, y=0 -> div_start never asserts; rsp_valid in accept+1 with q=255, r=5, err=1, id=1.
- rsp_ready held low for 6 cycles during RESP, with req0 valid -> payload stable every cycle; req_ready stays 0; req0 granted only in the cycle after the response handshake.
- div_done model tied low -> rsp_valid with err=1, q=0, r=0 after WIDTH+4 RUN cycles. The next request then completes normally.
- Assert reset during RUN, asynchronously between clock edges -> rsp_valid, busy, div_start and req_ready drop immediately. A subsequent 200/7 request returns q=28, r=4 with normal latency.
